fir_coef_ctrl: RTL

Runtime coefficient controller for the parameterised FIR filter. It accepts a coefficient set over a valid/ready config stream into a shadow bank and swaps banks atomically on a commit. It then masks FIR output-valid until the delay line holds no samples that mixed old and new coefficients. It sits between the host/config interface and the FIR: it drives the FIR's coefficient bus and qualifies its output valid.

---
 rtl/fir_coef_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fir_coef_ctrl.sv
// fir_coef_ctrl
//   Runtime coefficient controller for the FIR filter. A coefficient set is
//   streamed into the shadow bank over a valid/ready interface. It becomes
//   active when commit arrives while the set is armed. After a swap the
//   qualified output valid is held low until the FIR delay line no longer
//   holds samples that were filtered with a mix of old and new coefficients.
//
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   cfg_valid/ready  coefficient word handshake (cfg_data, tap 0 first)
//   cfg_last         marks the final word of a set
//   commit           single-cycle request to activate the armed set
//   busy             controller is not idle
//   err              one-cycle pulse after a malformed set
//   bank_sel         index of the active bank
//   coef_bus         active coefficients, tap k at [k*CW +: CW]
//   fir_valid_out    raw output valid from the FIR
//   out_valid        FIR output valid with post-swap samples masked
module fir_coef_ctrl #(
  parameter int TAPS  = 8,
  parameter int CW    = 16,
  parameter int LAT   = 1,
  parameter int FLUSH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CW-1:0]      cfg_data,
  input  logic               cfg_last,
  input  logic               commit,
  output logic               busy,
  output logic               err,
  output logic               bank_sel,
  output logic [TAPS*CW-1:0] coef_bus,
  input  logic               fir_valid_out,
  output logic               out_valid
);

  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int MW = ($clog2(TAPS + LAT) > 0) ? $clog2(TAPS + LAT) : 1;
  localparam logic [IW-1:0]      LAST_IDX  = IW'(TAPS - 1);
  localparam logic [MW-1:0]      MASK_INIT = MW'(TAPS - 1 + LAT);
  localparam logic [CW-1:0]      UNITY     = {1'b0, {(CW-1){1'b1}}};
  localparam logic [TAPS*CW-1:0] IDENT_BUS = (TAPS*CW)'(UNITY);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ARMED, ST_FLUSH} state_t;

  state_t             state, state_next;
  logic [IW-1:0]      idx, idx_next;
  logic [MW-1:0]      mask_cnt, mask_next;
  logic               bank_sel_next;
  logic               err_next;
  logic               wr_en;
  logic [TAPS*CW-1:0] bank0, bank1;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // IDLE and LOAD share one transfer rule: idx is always 0 in IDLE, so the
  // first word lands in tap 0 and the same length checks apply to every word.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    mask_next     = mask_cnt;
    bank_sel_next = bank_sel;
    err_next      = 1'b0;
    wr_en         = 1'b0;
    cfg_ready     = 1'b0;
    case (state)
      ST_IDLE, ST_LOAD: begin
        cfg_ready = rst;
        if (cfg_valid && rst) begin
          wr_en = 1'b1;
          if (idx == LAST_IDX) begin
            idx_next = '0;
            if (cfg_last) begin
              state_next = ST_ARMED;
            end else begin
              err_next   = 1'b1;
              state_next = ST_IDLE;
            end
          end else if (cfg_last) begin
            idx_next   = '0;
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            idx_next   = idx + IW'(1);
            state_next = ST_LOAD;
          end
        end
      end
      ST_ARMED: begin
        if (commit) begin
          bank_sel_next = ~bank_sel;
          if (FLUSH != 0 && MASK_INIT != '0) begin
            mask_next  = MASK_INIT;
            state_next = ST_FLUSH;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (mask_cnt == '0) begin
          state_next = ST_IDLE;
        end else if (fir_valid_out) begin
          mask_next = mask_cnt - MW'(1);
          if (mask_cnt == MW'(1)) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // coef_bus is loaded from the bank that will be active after this edge,
  // so the swap appears on the bus together with bank_sel. Samples taken by
  // the FIR on the commit edge still see the old bus value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_sel <= 1'b0;
      idx      <= '0;
      mask_cnt <= '0;
      err      <= 1'b0;
      bank0    <= IDENT_BUS;
      bank1    <= '0;
      coef_bus <= IDENT_BUS;
    end else begin
      bank_sel <= bank_sel_next;
      idx      <= idx_next;
      mask_cnt <= mask_next;
      err      <= err_next;
      if (wr_en) begin
        if (bank_sel) bank0[idx*CW +: CW] <= cfg_data;
        else          bank1[idx*CW +: CW] <= cfg_data;
      end
      coef_bus <= bank_sel_next ? bank1 : bank0;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign out_valid = fir_valid_out && (mask_cnt == '0);

endmodule
